controller: RTL and testbench
=============================

# controller

Instruction decode and control unit for the single-cycle ARM-subset datapath. It samples the current 32-bit instruction word and the NZCV flags and evaluates the condition field. It then produces registered write enables, ALU command and datapath mux selects for data-processing, single load/store and branch instructions.

## Interface
- No parameters.
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- IR_in  in  32  instruction word: cond[31:28], class[27:26], I[25], opcode[24:21], S/L[20], Rn[19:16], Rd[15:12], operand[11:0].
- Flags_in  in  4  current flags {N,Z,C,V}.
- Wen_ARd  out  1  register-file write enable for Rd.
- Wen_Dmem  out  1  data-memory write enable.
- Wen_Flags  out  1  flags-register write enable.
- cmd  out  5  ALU command, {1'b0, opcode} for data processing.
- select_X  out  1  writeback source: 0 = ALU result, 1 = memory read data.
- select_Y  out  1  PC source: 0 = PC+4, 1 = ALU result (branch target).
- select_src1  out  2  ALU operand A: 00 = Rn, 01 = zero, 10 = PC, 11 = reserved (treated as Rn).
- select_src2shift  out  3  ALU operand B: 000 = shifted register (imm or register shift amount), 001 = rotated imm8, 010 = zero-extended imm12, 011 = register offset Rm, 101 = sign-extended imm24<<2, others reserved (treated as 000).

## Operation
- Condition pass (cp) uses standard ARM codes on Flags_in: EQ, NE, CS, CC, MI, PL, VS, VC, HI (C & ~Z), LS, GE (N==V), LT, GT, LE, AL = 1; 1111 = never.
- Class 00, data processing:
  - cmd = {0, IR_in[24:21]}.
  - src2shift = 001 if I = 1, else 000.
  - src1 = 01 for MOV (1101) and MVN (1111), else 00.
  - Wen_ARd = cp, except TST/TEQ/CMP/CMN (10xx), which give 0.
  - Wen_Flags = cp & S.
  - select_X = 0, select_Y = 0.
- Class 01, load/store:
  - cmd = 00100 (ADD); U, P, W, B ignored; no base writeback.
  - src2shift = 010 if I = 0, else 011; src1 = 00.
  - L = 1: Wen_ARd = cp, select_X = 1.
  - L = 0: Wen_Dmem = cp, select_X = 0.
  - Wen_Flags = 0.
- Class 10, branch:
  - cmd = 00100, src1 = 10, src2shift = 101.
  - select_Y = cp; all write enables 0; bit 24 (link) ignored.
- Class 11: NOP. All enables 0, select_X/select_Y 0, cmd 00000, selects 00/000.
- Write enables and select_Y are never asserted when cp = 0. cmd and operand selects follow decode regardless of cp.

## Timing
- All outputs are registered. IR_in and Flags_in are sampled at rising edge k; outputs are valid after edge k and held until edge k+1. Latency is 1 cycle.
- Reset (RESET_N = 0 at a rising edge) takes priority over decode. After that edge, all outputs are 0 (cmd = 00000, selects = 0). The first decode is at the first edge with RESET_N = 1.
- Flags_in changing in the same cycle as IR_in: the values sampled at the same edge are used together.
- No handshakes; a new instruction is decoded every cycle.

## Configuration
- CTRL_COND_EXEC_EN defined: condition evaluation as above.
- CTRL_COND_EXEC_EN undefined: cp is forced to 1 for all cond values, including 1111, and Flags_in is unused.

## Structure
- Package controller_pkg holds:
  - condition-code enum (EQ..AL, NV);
  - data-processing opcode enum;
  - instruction-class constants;
  - src1 encodings (SRC1_RN, SRC1_ZERO, SRC1_PC);
  - src2shift encodings (SRC2_REGSH, SRC2_IMM8, SRC2_IMM12, SRC2_RM, SRC2_BRANCH);
  - ALU cmd ADD = 00100.
- Sub-module cond_check: combinational, (cond[3:0], flags[3:0]) -> pass.
- Top level holds decode logic and the output register.

## Test plan
- ADD R0,R1,R2,LSL R3 (0xE0810312), flags 0000 -> Wen_ARd 1, Wen_Flags 0, cmd 00100, src1 00, src2shift 000.
- ADDS R0,R1,R2,LSR #2 (0xE0910122) -> Wen_ARd 1, Wen_Flags 1, cmd 00100, src2shift 000. SUBEQS R0,R1,#2 (0x02510002), flags 0100 -> Wen_ARd 1, Wen_Flags 1, cmd 00010, src2shift 001.
- SUBNE R0,R2,#2 (0x12420002), flags 0100 -> Wen_ARd 0, Wen_Flags 0, cmd 00010, src2shift 001.
- LDR R0,[R1,#3] (0x04110003), flags 0100 -> Wen_ARd 1, select_X 1, cmd 00100, src2shift 010. STR R0,[R1,R2] (0x06010012), flags 0100 -> Wen_Dmem 1, Wen_ARd 0, src2shift 011.
- BHI (0x8A000008): flags 0010 -> select_Y 1, src1 10, src2shift 101, enables 0; flags 0000 -> select_Y 0, same src selects.
- Reset: RESET_N low during a valid ADD -> all outputs 0 after that edge; decode resumes 1 cycle after release.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared types and encodings for the ARM-subset instruction controller.
package controller_pkg;

  // Standard ARM condition field values; NV (1111) never executes.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Data-processing opcodes in IR[24:21].
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSC = 4'b0111,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } dp_op_e;

  // Instruction class in IR[27:26].
  localparam logic [1:0] CLASS_DP  = 2'b00;
  localparam logic [1:0] CLASS_LS  = 2'b01;
  localparam logic [1:0] CLASS_BR  = 2'b10;
  localparam logic [1:0] CLASS_NOP = 2'b11;

  // ALU operand A sources.
  localparam logic [1:0] SRC1_RN   = 2'b00;
  localparam logic [1:0] SRC1_ZERO = 2'b01;
  localparam logic [1:0] SRC1_PC   = 2'b10;

  // ALU operand B sources.
  localparam logic [2:0] SRC2_REGSH  = 3'b000;
  localparam logic [2:0] SRC2_IMM8   = 3'b001;
  localparam logic [2:0] SRC2_IMM12  = 3'b010;
  localparam logic [2:0] SRC2_RM     = 3'b011;
  localparam logic [2:0] SRC2_BRANCH = 3'b101;

  localparam logic [4:0] ALU_ADD = 5'b00100;

  // Complete set of registered control outputs.
  typedef struct packed {
    logic       wen_ard;
    logic       wen_dmem;
    logic       wen_flags;
    logic [4:0] cmd;
    logic       select_x;
    logic       select_y;
    logic [1:0] src1;
    logic [2:0] src2shift;
  } ctrl_t;

endpackage

// File: rtl/controller_cond_check.sv
// Combinational ARM condition-code evaluator: (cond, {N,Z,C,V}) -> pass.
module cond_check
  import controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Evaluate the condition field against the current flags.
  always_comb begin
    // NOTE: default first so every path assigns pass and no latch is inferred.
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Instruction decode and control unit for the single-cycle ARM-subset datapath.
// Outputs are registered: one cycle from IR_in/Flags_in sample to control.
// Build option: define CTRL_COND_EXEC_EN to enable conditional execution;
// when undefined every instruction executes and Flags_in is ignored.
module controller
  import controller_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [31:0] IR_in,
  input  logic [3:0]  Flags_in,
  output logic        Wen_ARd,
  output logic        Wen_Dmem,
  output logic        Wen_Flags,
  output logic [4:0]  cmd,
  output logic        select_X,
  output logic        select_Y,
  output logic [1:0]  select_src1,
  output logic [2:0]  select_src2shift
);

  logic [1:0] ir_class;
  logic       i_bit;
  dp_op_e     opcode;
  logic       sl_bit;
  logic       cp;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  assign ir_class = IR_in[27:26];
  assign i_bit    = IR_in[25];
  assign opcode   = dp_op_e'(IR_in[24:21]);
  assign sl_bit   = IR_in[20];

`ifdef CTRL_COND_EXEC_EN
  cond_check u_cond_check (
    .cond  (IR_in[31:28]),
    .flags (Flags_in),
    .pass  (cp)
  );

  logic unused_ir;
  assign unused_ir = ^IR_in[19:0];
`else
  assign cp = 1'b1;

  logic unused_ir;
  assign unused_ir = ^{IR_in[31:28], IR_in[19:0], Flags_in};
`endif

  // Decode the instruction into next-cycle control; enables gated by cp.
  always_comb begin
    ctrl_d = '0;
    case (ir_class)
      CLASS_DP: begin
        ctrl_d.cmd       = {1'b0, opcode};
        ctrl_d.src2shift = i_bit ? SRC2_IMM8 : SRC2_REGSH;
        ctrl_d.src1      = (opcode == OP_MOV || opcode == OP_MVN) ? SRC1_ZERO : SRC1_RN;
        // TST/TEQ/CMP/CMN (10xx) only update flags.
        ctrl_d.wen_ard   = cp & (opcode[3:2] != 2'b10);
        ctrl_d.wen_flags = cp & sl_bit;
      end
      CLASS_LS: begin
        ctrl_d.cmd       = ALU_ADD;
        ctrl_d.src1      = SRC1_RN;
        ctrl_d.src2shift = i_bit ? SRC2_RM : SRC2_IMM12;
        if (sl_bit) begin
          ctrl_d.wen_ard  = cp;
          ctrl_d.select_x = 1'b1;
        end else begin
          ctrl_d.wen_dmem = cp;
        end
      end
      CLASS_BR: begin
        ctrl_d.cmd       = ALU_ADD;
        ctrl_d.src1      = SRC1_PC;
        ctrl_d.src2shift = SRC2_BRANCH;
        ctrl_d.select_y  = cp;
      end
      default: ctrl_d = '0;
    endcase
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: non-blocking so all flops update together from pre-edge values.
    if (!RESET_N) ctrl_q <= '0;
    else          ctrl_q <= ctrl_d;
  end

  assign Wen_ARd          = ctrl_q.wen_ard;
  assign Wen_Dmem         = ctrl_q.wen_dmem;
  assign Wen_Flags        = ctrl_q.wen_flags;
  assign cmd              = ctrl_q.cmd;
  assign select_X         = ctrl_q.select_x;
  assign select_Y         = ctrl_q.select_y;
  assign select_src1      = ctrl_q.src1;
  assign select_src2shift = ctrl_q.src2shift;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: driver pushes expected outputs, monitor
// pops and compares one cycle later.
module tb_controller;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [31:0] IR_in    = '0;
  logic [3:0]  Flags_in = '0;
  logic        Wen_ARd, Wen_Dmem, Wen_Flags, select_X, select_Y;
  logic [4:0]  cmd;
  logic [1:0]  select_src1;
  logic [2:0]  select_src2shift;

  controller dut (
    .CLOCK_50         (CLOCK_50),
    .RESET_N          (RESET_N),
    .IR_in            (IR_in),
    .Flags_in         (Flags_in),
    .Wen_ARd          (Wen_ARd),
    .Wen_Dmem         (Wen_Dmem),
    .Wen_Flags        (Wen_Flags),
    .cmd              (cmd),
    .select_X         (select_X),
    .select_Y         (select_Y),
    .select_src1      (select_src1),
    .select_src2shift (select_src2shift)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic       ard;
    logic       dmem;
    logic       flg;
    logic [4:0] cmd;
    logic       x;
    logic       y;
    logic [1:0] s1;
    logic [2:0] s2;
  } exp_t;

  // Directed vector: enables listed as they would be if the condition passes;
  // cp is the hand-evaluated condition result for the given flags.
  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic        cp;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  int   tag_q[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int tag, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, tag, act, req);
    end
  endtask

  task automatic add(input string name, input logic [31:0] ir, input logic [3:0] fl, input logic cp,
                     input logic ard, input logic dmem, input logic flg, input logic [4:0] c,
                     input logic x, input logic y, input logic [1:0] s1, input logic [2:0] s2);
    vec_t v;
    v.name = name; v.ir = ir; v.flags = fl; v.cp = cp;
    v.e = '{ard: ard, dmem: dmem, flg: flg, cmd: c, x: x, y: y, s1: s1, s2: s2};
    vecs.push_back(v);
  endtask

  // Apply one cycle of stimulus at the falling edge and record its expectation.
  task automatic drive(input logic rst_n, input logic [31:0] ir, input logic [3:0] fl, input exp_t e, input int tag);
    @(negedge CLOCK_50);
    RESET_N  = rst_n;
    IR_in    = ir;
    Flags_in = fl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic exp_t gate(input vec_t v);
    exp_t r;
    logic cp_eff;
`ifdef CTRL_COND_EXEC_EN
    cp_eff = v.cp;
`else
    cp_eff = 1'b1;
`endif
    r = v.e;
    r.ard  = v.e.ard  & cp_eff;
    r.dmem = v.e.dmem & cp_eff;
    r.flg  = v.e.flg  & cp_eff;
    r.y    = v.e.y    & cp_eff;
    return r;
  endfunction

  // Monitor: outputs for stimulus applied before an edge are compared just after it.
  initial begin
    exp_t e;
    int   t;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check("Wen_ARd",          t, {7'd0, Wen_ARd},          {7'd0, e.ard});
        check("Wen_Dmem",         t, {7'd0, Wen_Dmem},         {7'd0, e.dmem});
        check("Wen_Flags",        t, {7'd0, Wen_Flags},        {7'd0, e.flg});
        check("cmd",              t, {3'd0, cmd},              {3'd0, e.cmd});
        check("select_X",         t, {7'd0, select_X},         {7'd0, e.x});
        check("select_Y",         t, {7'd0, select_Y},         {7'd0, e.y});
        check("select_src1",      t, {6'd0, select_src1},      {6'd0, e.s1});
        check("select_src2shift", t, {5'd0, select_src2shift}, {5'd0, e.s2});
      end
    end
  end

  localparam logic [31:0] ADD_RSH = 32'hE0810312;

  initial begin
    exp_t zero_e;
    exp_t add_e;
    int   step;
    zero_e = '0;
    add_e  = '{ard: 1'b1, dmem: 1'b0, flg: 1'b0, cmd: 5'b00100, x: 1'b0, y: 1'b0, s1: 2'b00, s2: 3'b000};

    //   name        ir            flags    cp    ard  dmem flg  cmd       x    y    s1     s2
    add("ADD_rsh",   32'hE0810312, 4'b0000, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDS_lsr",  32'hE0910122, 4'b0000, 1'b1, 1'b1,1'b0,1'b1,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("SUBEQS",    32'h02510002, 4'b0100, 1'b1, 1'b1,1'b0,1'b1,5'b00010,1'b0,1'b0,2'b00,3'b001);
    add("SUBNE",     32'h12420002, 4'b0100, 1'b0, 1'b1,1'b0,1'b0,5'b00010,1'b0,1'b0,2'b00,3'b001);
    add("LDR_imm",   32'h04110003, 4'b0100, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b1,1'b0,2'b00,3'b010);
    add("STR_reg",   32'h06010012, 4'b0100, 1'b1, 1'b0,1'b1,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b011);
    add("BHI_taken", 32'h8A000008, 4'b0010, 1'b1, 1'b0,1'b0,1'b0,5'b00100,1'b0,1'b1,2'b10,3'b101);
    add("BHI_not",   32'h8A000008, 4'b0000, 1'b0, 1'b0,1'b0,1'b0,5'b00100,1'b0,1'b1,2'b10,3'b101);
    add("MOV_imm",   32'hE3A00005, 4'b0000, 1'b1, 1'b1,1'b0,1'b0,5'b01101,1'b0,1'b0,2'b01,3'b001);
    add("MVNS_reg",  32'hE1F01002, 4'b0000, 1'b1, 1'b1,1'b0,1'b1,5'b01111,1'b0,1'b0,2'b01,3'b000);
    add("CMP_imm",   32'hE3510000, 4'b0000, 1'b1, 1'b0,1'b0,1'b1,5'b01010,1'b0,1'b0,2'b00,3'b001);
    add("TST_reg",   32'hE1110002, 4'b0000, 1'b1, 1'b0,1'b0,1'b1,5'b01000,1'b0,1'b0,2'b00,3'b000);
    add("NOP_cls11", 32'hEF000000, 4'b1111, 1'b1, 1'b0,1'b0,1'b0,5'b00000,1'b0,1'b0,2'b00,3'b000);
    add("ADD_NV",    32'hF0810002, 4'b0100, 1'b0, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("LDRNE",     32'h14110003, 4'b0100, 1'b0, 1'b1,1'b0,1'b0,5'b00100,1'b1,1'b0,2'b00,3'b010);
    add("STRNE_imm", 32'h14010003, 4'b0100, 1'b0, 1'b0,1'b1,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b010);
    add("ADDNE",     32'h10810002, 4'b0000, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDCS",     32'h20810002, 4'b0010, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDCC",     32'h30810002, 4'b0010, 1'b0, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDMI",     32'h40810002, 4'b1000, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDPL",     32'h50810002, 4'b1000, 1'b0, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDVS",     32'h60810002, 4'b0001, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDVC",     32'h70810002, 4'b0001, 1'b0, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDLS",     32'h90810002, 4'b0110, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDGE",     32'hA0810002, 4'b1000, 1'b0, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDLT",     32'hB0810002, 4'b1000, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDGT",     32'hC0810002, 4'b1001, 1'b1, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);
    add("ADDLE",     32'hD0810002, 4'b1001, 1'b0, 1'b1,1'b0,1'b0,5'b00100,1'b0,1'b0,2'b00,3'b000);

    step = 0;
    // Reset held across two edges with a valid ADD on the bus.
    drive(1'b0, ADD_RSH, 4'b0000, zero_e, step++);
    drive(1'b0, ADD_RSH, 4'b0000, zero_e, step++);

    foreach (vecs[i]) drive(1'b1, vecs[i].ir, vecs[i].flags, gate(vecs[i]), step++);

    // Reset asserted mid-stream during a valid ADD, then decode resumes.
    drive(1'b0, ADD_RSH, 4'b0000, zero_e, step++);
    drive(1'b1, ADD_RSH, 4'b0000, add_e,  step++);
    drive(1'b1, 32'hEF000000, 4'b0000, zero_e, step++);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLOCK_50);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
